branch_control_unit: RTL and testbench

BRANCH_CONTROL_UNIT -- requirements
Module: branch_control_unit

---
 rtl/branch_pkg.sv | 19 +
 rtl/branch_control_unit_if.sv | 33 +++
 rtl/nzcv_register.sv | 44 ++++
 rtl/branch_control_unit.sv | 129 ++++++++++++
 tb/tb_branch_control_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch control unit.
//   - bcu_state_e : redirect sequencer states (IDLE -> REDIRECT -> DRAIN -> IDLE)
//   - FLAG_*      : bit positions of N, Z, C, V inside the 4-bit flags word
//   - NZCV_W      : width of the flags word
package branch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } bcu_state_e;

    localparam int NZCV_W = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/branch_control_unit_if.sv
// Bundle between the Execute stage / hazard unit and the branch control unit.
//   master : pipeline side, drives Execute-stage information, receives redirect/flush
//   slave  : branch control unit side
// Inputs to the unit : StallE, ValidE, BranchE, CondExE, FlagWriteE, ALUFlagsE, BranchTargetE
// Outputs of the unit: Flags, PCSrc, PCTarget, FlushD, FlushE, TakenCount
interface branch_control_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              StallE;
    logic              ValidE;
    logic              BranchE;
    logic              CondExE;
    logic              FlagWriteE;
    logic [3:0]        ALUFlagsE;
    logic [ADDR_W-1:0] BranchTargetE;
    logic [3:0]        Flags;
    logic              PCSrc;
    logic [ADDR_W-1:0] PCTarget;
    logic              FlushD;
    logic              FlushE;
    logic [CNT_W-1:0]  TakenCount;

    modport master (
        output StallE, ValidE, BranchE, CondExE, FlagWriteE, ALUFlagsE, BranchTargetE,
        input  Flags, PCSrc, PCTarget, FlushD, FlushE, TakenCount
    );

    modport slave (
        input  StallE, ValidE, BranchE, CondExE, FlagWriteE, ALUFlagsE, BranchTargetE,
        output Flags, PCSrc, PCTarget, FlushD, FlushE, TakenCount
    );
endinterface

// File: rtl/nzcv_register.sv
// Architectural NZCV flags register: 4-bit register with load enable and
// asynchronous active-low reset to all zeros.
//   clk, rst_n : clock / async reset
//   en_i       : load d_i at the rising edge
//   d_i        : new flags {N,Z,C,V}
//   q_o        : stored flags {N,Z,C,V}
module nzcv_register
    import branch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [NZCV_W-1:0] d_i,
    output logic [NZCV_W-1:0] q_o
);

    logic [NZCV_W-1:0] flags_q;
    logic [NZCV_W-1:0] flags_d;

    // Next-state: load all four flags together or hold.
    always_comb begin
        flags_d = flags_q;
        if (en_i) begin
            flags_d[FLAG_N] = d_i[FLAG_N];
            flags_d[FLAG_Z] = d_i[FLAG_Z];
            flags_d[FLAG_C] = d_i[FLAG_C];
            flags_d[FLAG_V] = d_i[FLAG_V];
        end else begin
            flags_d = flags_q;
        end
    end

    // Flags storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign q_o = flags_q;

endmodule

// File: rtl/branch_control_unit.sv
// Branch control unit: resolves taken branches in Execute, redirects fetch,
// squashes the two wrong-path instructions behind the branch, keeps the
// architectural NZCV flags and counts taken branches (saturating).
//   clk, rst_n : clock / asynchronous active-low reset
//   bus        : branch_control_unit_if.slave
//                in : StallE, ValidE, BranchE, CondExE, FlagWriteE, ALUFlagsE, BranchTargetE
//                out: Flags, PCSrc, PCTarget, FlushD, FlushE, TakenCount (all registered)
module branch_control_unit
    import branch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_control_unit_if.slave  bus
);

    bcu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pcsrc_q, pcsrc_d;
    logic              flushd_q, flushd_d;
    logic              flushe_q, flushe_d;

    logic              commit_s;
    logic              take_s;
    logic              flag_we_s;

    // Saturating +1: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Only a valid, unstalled instruction seen while IDLE is architecturally
    // real; anything arriving during REDIRECT/DRAIN is wrong-path.
    assign commit_s  = bus.ValidE & ~bus.StallE & (state_q == IDLE);
    assign take_s    = commit_s & bus.BranchE & bus.CondExE;
    assign flag_we_s = commit_s & bus.FlagWriteE & bus.CondExE;

    // Sequencer next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        count_d  = count_q;
        pcsrc_d  = pcsrc_q;
        flushd_d = flushd_q;
        flushe_d = flushe_q;
        if (bus.StallE) begin
            // Frozen: everything keeps its current value.
            state_d  = state_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_s) begin
                        state_d  = REDIRECT;
                        target_d = bus.BranchTargetE;
                        count_d  = sat_inc(count_q);
                        pcsrc_d  = 1'b1;
                        flushd_d = 1'b1;
                        flushe_d = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        pcsrc_d  = 1'b0;
                        flushd_d = 1'b0;
                        flushe_d = 1'b0;
                    end
                end
                REDIRECT: begin
                    // Second wrong-path instruction is still in Decode.
                    state_d  = DRAIN;
                    pcsrc_d  = 1'b0;
                    flushd_d = 1'b1;
                    flushe_d = 1'b0;
                end
                DRAIN: begin
                    state_d  = IDLE;
                    pcsrc_d  = 1'b0;
                    flushd_d = 1'b0;
                    flushe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    pcsrc_d  = 1'b0;
                    flushd_d = 1'b0;
                    flushe_d = 1'b0;
                end
            endcase
        end
    end

    // Sequencer, redirect target, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= {ADDR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            pcsrc_q  <= 1'b0;
            flushd_q <= 1'b0;
            flushe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            count_q  <= count_d;
            pcsrc_q  <= pcsrc_d;
            flushd_q <= flushd_d;
            flushe_q <= flushe_d;
        end
    end

    nzcv_register u_nzcv (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (flag_we_s),
        .d_i   (bus.ALUFlagsE),
        .q_o   (bus.Flags)
    );

    assign bus.PCSrc      = pcsrc_q;
    assign bus.PCTarget   = target_q;
    assign bus.FlushD     = flushd_q;
    assign bus.FlushE     = flushe_q;
    assign bus.TakenCount = count_q;

endmodule

// File: tb/tb_branch_control_unit.sv
module tb_branch_control_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    branch_control_unit_if #(.ADDR_W(32), .CNT_W(16)) bus ();
    branch_control_unit_if #(.ADDR_W(32), .CNT_W(4))  bus2 ();

    branch_control_unit #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Narrow-counter instance used only to reach saturation quickly.
    branch_control_unit #(.ADDR_W(32), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a branch occupies the redirect window for two cycles
    // (remaining = 2 then 1); flags and counter follow the commit rules.
    int          m_remaining = 0;
    logic [3:0]  m_flags     = 4'h0;
    logic [31:0] m_target    = 32'h0;
    int          m_count     = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_remaining <= 0;
            m_flags     <= 4'h0;
            m_target    <= 32'h0;
            m_count     <= 0;
        end else if (!bus.StallE) begin
            if (m_remaining > 0) begin
                m_remaining <= m_remaining - 1;
            end else if (bus.ValidE) begin
                if (bus.FlagWriteE && bus.CondExE) m_flags <= bus.ALUFlagsE;
                if (bus.BranchE && bus.CondExE) begin
                    m_remaining <= 2;
                    m_target    <= bus.BranchTargetE;
                    m_count     <= (m_count >= 65535) ? 65535 : m_count + 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("PCSrc",      64'(bus.PCSrc),      64'(m_remaining == 2));
        check("FlushD",     64'(bus.FlushD),     64'(m_remaining != 0));
        check("FlushE",     64'(bus.FlushE),     64'(m_remaining == 2));
        check("PCTarget",   64'(bus.PCTarget),   64'(m_target));
        check("Flags",      64'(bus.Flags),      64'(m_flags));
        check("TakenCount", 64'(bus.TakenCount), 64'(m_count));
    end

    task automatic step(input logic v, input logic b, input logic c, input logic fw,
                        input logic [3:0] fl, input logic [31:0] tgt, input logic st);
        bus.ValidE        = v;
        bus.BranchE       = b;
        bus.CondExE       = c;
        bus.FlagWriteE    = fw;
        bus.ALUFlagsE     = fl;
        bus.BranchTargetE = tgt;
        bus.StallE        = st;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic outs(input string tag, input logic p, input logic fd, input logic fe);
        check({tag, "_PCSrc"},  64'(bus.PCSrc),  64'(p));
        check({tag, "_FlushD"}, 64'(bus.FlushD), 64'(fd));
        check({tag, "_FlushE"}, 64'(bus.FlushE), 64'(fe));
    endtask

    initial begin
        bus.ValidE = 1'b0; bus.BranchE = 1'b0; bus.CondExE = 1'b0; bus.FlagWriteE = 1'b0;
        bus.ALUFlagsE = 4'h0; bus.BranchTargetE = 32'h0; bus.StallE = 1'b0;
        bus2.ValidE = 1'b0; bus2.BranchE = 1'b0; bus2.CondExE = 1'b0; bus2.FlagWriteE = 1'b0;
        bus2.ALUFlagsE = 4'h0; bus2.BranchTargetE = 32'h0; bus2.StallE = 1'b0;

        // Reset state
        #1;
        outs("rst", 1'b0, 1'b0, 1'b0);
        check("rst_count", 64'(bus.TakenCount), 64'h0);
        check("rst_flags", 64'(bus.Flags), 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();

        // Taken branch to 0x40
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0000_0040, 1'b0);
        outs("take_redir", 1'b1, 1'b1, 1'b1);
        check("take_target", 64'(bus.PCTarget), 64'h40);
        check("take_count", 64'(bus.TakenCount), 64'h1);
        idle();
        outs("take_drain", 1'b0, 1'b1, 1'b0);
        idle();
        outs("take_idle", 1'b0, 1'b0, 1'b0);

        // Not-taken branch
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0000_0080, 1'b0);
        outs("nt_c1", 1'b0, 1'b0, 1'b0);
        idle();
        outs("nt_c2", 1'b0, 1'b0, 1'b0);
        idle();
        outs("nt_c3", 1'b0, 1'b0, 1'b0);
        check("nt_count", 64'(bus.TakenCount), 64'h1);
        check("nt_target", 64'(bus.PCTarget), 64'h40);

        // Flag writes: conditional pass then conditional fail
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 32'h0, 1'b0);
        check("flags_load", 64'(bus.Flags), 64'h4);
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h0, 1'b0);
        check("flags_hold", 64'(bus.Flags), 64'h4);

        // Branch and flag write together
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1010, 32'h0000_0100, 1'b0);
        check("both_flags", 64'(bus.Flags), 64'hA);
        outs("both", 1'b1, 1'b1, 1'b1);
        check("both_count", 64'(bus.TakenCount), 64'h2);
        idle();
        idle();

        // Stall in IDLE blocks a take
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, 32'h0000_0500, 1'b1);
        outs("stall_idle", 1'b0, 1'b0, 1'b0);
        check("stall_idle_flags", 64'(bus.Flags), 64'hA);
        idle();

        // Take, then stall three cycles in REDIRECT
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0000_0200, 1'b0);
        outs("stall_r0", 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 32'h0000_0600, 1'b1);
            outs("stall_rn", 1'b1, 1'b1, 1'b1);
        end
        // Unstall with a wrong-path branch in REDIRECT
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 32'h0000_0300, 1'b0);
        outs("stall_drain", 1'b0, 1'b1, 1'b0);
        // Back-to-back branch while in DRAIN
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 32'h0000_0300, 1'b0);
        outs("drain_b2b", 1'b0, 1'b0, 1'b0);
        check("drain_count", 64'(bus.TakenCount), 64'h3);
        check("drain_target", 64'(bus.PCTarget), 64'h200);
        check("drain_flags", 64'(bus.Flags), 64'hA);
        idle();

        // Reset asserted mid-REDIRECT
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0000_0400, 1'b0);
        outs("pre_rst", 1'b1, 1'b1, 1'b1);
        bus.ValidE = 1'b0; bus.BranchE = 1'b0; bus.CondExE = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        outs("mid_rst", 1'b0, 1'b0, 1'b0);
        check("mid_rst_target", 64'(bus.PCTarget), 64'h0);
        check("mid_rst_count", 64'(bus.TakenCount), 64'h0);
        check("mid_rst_flags", 64'(bus.Flags), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();
        outs("post_rst", 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0000_0044, 1'b0);
        outs("post_rst_take", 1'b1, 1'b1, 1'b1);
        idle();
        idle();

        // Saturation on the 4-bit-counter instance: 15 takes reach all-ones, 3 more must not wrap
        for (int i = 0; i < 18; i++) begin
            bus2.ValidE = 1'b1; bus2.BranchE = 1'b1; bus2.CondExE = 1'b1;
            bus2.BranchTargetE = 32'(i * 4);
            @(posedge clk); #1;
            bus2.ValidE = 1'b0;
            check("sat_count", 64'(bus2.TakenCount), 64'((i + 1 > 15) ? 15 : i + 1));
            check("sat_pcsrc", 64'(bus2.PCSrc), 64'h1);
            @(posedge clk);
            @(posedge clk); #1;
        end
        check("sat_final", 64'(bus2.TakenCount), 64'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
